multiplicador_secuencial: RTL and testbench

MULTIPLICADOR_SECUENCIAL -- requirements
Module: multiplicador_secuencial

---
 rtl/multiplicador_secuencial_pkg.sv | 13 +
 rtl/saturacion_punto_fijo.sv | 45 ++++
 rtl/multiplicador_secuencial.sv | 154 +++++++++++++++
 tb/tb_multiplicador_secuencial.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/multiplicador_secuencial_pkg.sv
// Shared definitions for the sequential shift-add fixed-point multiplier.
package multiplicador_secuencial_pkg;

    localparam int N_DEF    = 24;
    localparam int FRAC_DEF = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } estado_t;

endpackage

// File: rtl/saturacion_punto_fijo.sv
// Rescales a 2N-bit product back to the N-bit operand format (>> FRAC)
// and clamps it to the representable range, flagging when it clamps.
module saturacion_punto_fijo #(
    parameter int N      = 24,
    parameter int FRAC   = 12,
    parameter int SIGNED = 1
) (
    input  logic [2*N-1:0] producto,
    output logic [N-1:0]   resultado,
    output logic           overflow
);

    logic [2*N-1:0] desplazado;

    generate
        if (SIGNED != 0) begin : g_con_signo
            // Arithmetic shift floors toward minus infinity; the value fits
            // when every bit above the N-bit sign position matches it.
            always_comb begin
                desplazado = $signed(producto) >>> FRAC;
                if ((&desplazado[2*N-1:N-1]) || ~(|desplazado[2*N-1:N-1])) begin
                    resultado = desplazado[N-1:0];
                    overflow  = 1'b0;
                end else begin
                    resultado = desplazado[2*N-1] ? {1'b1, {(N-1){1'b0}}}
                                                  : {1'b0, {(N-1){1'b1}}};
                    overflow  = 1'b1;
                end
            end
        end else begin : g_sin_signo
            // Unsigned: fits when nothing is left above bit N-1.
            always_comb begin
                desplazado = producto >> FRAC;
                if (~(|desplazado[2*N-1:N])) begin
                    resultado = desplazado[N-1:0];
                    overflow  = 1'b0;
                end else begin
                    resultado = {N{1'b1}};
                    overflow  = 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/multiplicador_secuencial.sv
// Sequential radix-2 shift-add multiplier for N-bit fixed-point operands.
// Operands are reduced to magnitudes at accept time, multiplied in N
// shift-add steps, then sign-corrected, rescaled and saturated on FIN entry.
// Fixed latency: Listo is high N+1 edges after the accepting edge.
module multiplicador_secuencial
    import multiplicador_secuencial_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int FRAC   = FRAC_DEF,
    parameter int SIGNED = 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           Inicio,
    input  logic [N-1:0]   Multiplicandos,
    input  logic [N-1:0]   Constantes,
    output logic           Ocupado,
    output logic           Listo,
    output logic [2*N-1:0] Multip,
    output logic [N-1:0]   Resultado,
    output logic           Overflow
);

    localparam int CW = $clog2(N + 1);

    estado_t        estado_q, estado_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   mcand_q, mcand_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic           signo_q, signo_d;
    logic [2*N-1:0] multip_q, multip_d;
    logic [N-1:0]   resultado_q, resultado_d;
    logic           overflow_q, overflow_d;

    logic           neg_a, neg_b;
    logic [N-1:0]   mag_a, mag_b;
    logic [N:0]     suma;
    logic [2*N-1:0] paso;
    logic [2*N-1:0] producto_con_signo;
    logic [N-1:0]   sat_resultado;
    logic           sat_overflow;
    logic           ultimo;

    // The counter runs 0..N in CALC: N shift-add steps, and the cycle with
    // cnt_q == N registers the finished product on the way into FIN.
    assign ultimo = (cnt_q == CW'(N));

    // Operand magnitudes and result sign; -2^(N-1) negates to 2^(N-1) unsigned.
    always_comb begin
        neg_a = (SIGNED != 0) && Multiplicandos[N-1];
        neg_b = (SIGNED != 0) && Constantes[N-1];
        mag_a = neg_a ? -Multiplicandos : Multiplicandos;
        mag_b = neg_b ? -Constantes     : Constantes;
    end

    // One radix-2 step: the multiplier sits in the low half of the
    // accumulator and is consumed LSB-first as the partial sum shifts in.
    always_comb begin
        suma               = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        paso               = {suma, acc_q[N-1:1]};
        producto_con_signo = signo_q ? -acc_q : acc_q;
    end

    saturacion_punto_fijo #(
        .N      (N),
        .FRAC   (FRAC),
        .SIGNED (SIGNED)
    ) u_sat (
        .producto  (producto_con_signo),
        .resultado (sat_resultado),
        .overflow  (sat_overflow)
    );

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) estado_q <= IDLE;
        else     estado_q <= estado_d;
    end

    // Next-state logic: FIN always falls back to IDLE.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            IDLE:    if (Inicio) estado_d = CALC;
            CALC:    if (ultimo) estado_d = FIN;
            FIN:     estado_d = IDLE;
            default: estado_d = IDLE;
        endcase
    end

    // FSM outputs: busy through CALC and FIN, Listo only during FIN.
    always_comb begin
        Ocupado = (estado_q != IDLE);
        Listo   = (estado_q == FIN);
    end

    // Datapath next values: capture on accept, step in CALC, publish at the end.
    always_comb begin
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        signo_d     = signo_q;
        multip_d    = multip_q;
        resultado_d = resultado_q;
        overflow_d  = overflow_q;
        case (estado_q)
            IDLE: begin
                if (Inicio) begin
                    mcand_d = mag_a;
                    acc_d   = {{N{1'b0}}, mag_b};
                    signo_d = neg_a ^ neg_b;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                if (!ultimo) begin
                    acc_d = paso;
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    multip_d    = producto_con_signo;
                    resultado_d = sat_resultado;
                    overflow_d  = sat_overflow;
                end
            end
            default: ;
        endcase
    end

    // Datapath and result registers; results hold until the next FIN.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q       <= '0;
            mcand_q     <= '0;
            acc_q       <= '0;
            signo_q     <= 1'b0;
            multip_q    <= '0;
            resultado_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            signo_q     <= signo_d;
            multip_q    <= multip_d;
            resultado_q <= resultado_d;
            overflow_q  <= overflow_d;
        end
    end

    assign Multip    = multip_q;
    assign Resultado = resultado_q;
    assign Overflow  = overflow_q;

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Scoreboard bench: a signed and an unsigned instance share stimulus; the
// driver pushes integer-arithmetic expectations, the monitor checks on Listo.
module tb_multiplicador_secuencial;

    localparam int N    = 24;
    localparam int FRAC = 12;

    logic clk = 1'b0;
    logic rst;
    logic inicio;
    logic [N-1:0] op_a, op_b;

    logic           ocup_s, listo_s, ovf_s, ocup_u, listo_u, ovf_u;
    logic [2*N-1:0] mult_s, mult_u;
    logic [N-1:0]   res_s, res_u;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [2*N-1:0] m;
        logic [N-1:0]   r;
        logic           o;
        int             cyc;
    } exp_t;

    exp_t q_s[$];
    exp_t q_u[$];
    exp_t e_s, e_u;

    multiplicador_secuencial #(.N(N), .FRAC(FRAC), .SIGNED(1)) dut_s (
        .CLK(clk), .RST(rst), .Inicio(inicio),
        .Multiplicandos(op_a), .Constantes(op_b),
        .Ocupado(ocup_s), .Listo(listo_s), .Multip(mult_s),
        .Resultado(res_s), .Overflow(ovf_s)
    );

    multiplicador_secuencial #(.N(N), .FRAC(FRAC), .SIGNED(0)) dut_u (
        .CLK(clk), .RST(rst), .Inicio(inicio),
        .Multiplicandos(op_a), .Constantes(op_b),
        .Ocupado(ocup_u), .Listo(listo_u), .Multip(mult_u),
        .Resultado(res_u), .Overflow(ovf_u)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference: exact integer product, floor-shift, clamp to the N-bit range.
    function automatic exp_t modelo(input logic [N-1:0] a, input logic [N-1:0] b, input bit sgn);
        longint pa, pb, p, s, maxv, minv;
        exp_t e;
        pa = longint'({40'd0, a});
        pb = longint'({40'd0, b});
        if (sgn) begin
            if (a[N-1]) pa = pa - (longint'(1) << N);
            if (b[N-1]) pb = pb - (longint'(1) << N);
            maxv = (longint'(1) << (N-1)) - 1;
            minv = -(longint'(1) << (N-1));
        end else begin
            maxv = (longint'(1) << N) - 1;
            minv = 0;
        end
        p   = pa * pb;
        s   = p >>> FRAC;
        e.m = p[2*N-1:0];
        if (s > maxv) begin
            e.r = maxv[N-1:0];
            e.o = 1'b1;
        end else if (s < minv) begin
            e.r = minv[N-1:0];
            e.o = 1'b1;
        end else begin
            e.r = s[N-1:0];
            e.o = 1'b0;
        end
        e.cyc = 0;
        return e;
    endfunction

    // Monitor: every Listo must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (listo_s) begin
                if (q_s.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL signed unexpected Listo: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e_s = q_s.pop_front();
                    chk("signed Multip",    64'(mult_s), 64'(e_s.m));
                    chk("signed Resultado", 64'(res_s),  64'(e_s.r));
                    chk("signed Overflow",  64'(ovf_s),  64'(e_s.o));
                    chk("signed latency",   64'(cyc),    64'(e_s.cyc));
                end
            end
            if (listo_u) begin
                if (q_u.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unsigned unexpected Listo: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e_u = q_u.pop_front();
                    chk("unsigned Multip",    64'(mult_u), 64'(e_u.m));
                    chk("unsigned Resultado", 64'(res_u),  64'(e_u.r));
                    chk("unsigned Overflow",  64'(ovf_u),  64'(e_u.o));
                    chk("unsigned latency",   64'(cyc),    64'(e_u.cyc));
                end
            end
        end
    end

    // One operation: accept, scramble operands afterwards, optionally poke
    // Inicio mid-CALC, count busy cycles, then check the held results.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit poke);
        exp_t es, eu;
        int busy;
        @(negedge clk);
        op_a = a; op_b = b; inicio = 1'b1;
        es = modelo(a, b, 1'b1);
        eu = modelo(a, b, 1'b0);
        @(posedge clk); #1;
        es.cyc = cyc + N + 1;
        eu.cyc = cyc + N + 1;
        q_s.push_back(es);
        q_u.push_back(eu);
        busy = 0;
        for (int k = 0; k < N + 3; k++) begin
            @(negedge clk);
            inicio = poke && (k == 5);
            op_a = N'($urandom);
            op_b = N'($urandom);
            if (ocup_s && ocup_u) busy++;
        end
        chk("Ocupado cycles",         64'(busy),   64'(N + 2));
        chk("signed Multip hold",     64'(mult_s), 64'(es.m));
        chk("unsigned Resultado hold", 64'(res_u), 64'(eu.r));
    endtask

    logic [N-1:0] tab_a [8];
    logic [N-1:0] tab_b [8];

    initial begin
        rst = 1'b1; inicio = 1'b0; op_a = '0; op_b = '0;
        tab_a = '{24'h000000, 24'h7FFFFF, 24'hFFFFFF, 24'h800000, 24'h800000, 24'h000001, 24'hFFF000, 24'h123456};
        tab_b = '{24'h5A5A5A, 24'h7FFFFF, 24'hFFFFFF, 24'h7FFFFF, 24'hFFFFFF, 24'h800000, 24'h001000, 24'h000000};
        repeat (3) @(negedge clk);
        chk("reset Ocupado",   64'(ocup_s), 64'd0);
        chk("reset Listo",     64'(listo_s), 64'd0);
        chk("reset Multip",    64'(mult_s), 64'd0);
        chk("reset Resultado", 64'(res_s),  64'd0);
        chk("reset Overflow",  64'(ovf_u),  64'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op(24'd3, 24'd5, 1'b0);
        chk("3x5 Multip",    64'(mult_u), 64'd15);
        chk("3x5 Resultado", 64'(res_u),  64'd0);
        chk("3x5 Overflow",  64'(ovf_u),  64'd0);

        do_op(24'hFFFFFF, 24'h000002, 1'b0);
        chk("-1x2 Multip",    64'(mult_s), 64'h0000_FFFF_FFFF_FFFE);
        chk("-1x2 Resultado", 64'(res_s),  64'h0000_0000_00FF_FFFF);
        chk("-1x2 Overflow",  64'(ovf_s),  64'd0);

        do_op(24'h001800, 24'h002000, 1'b0);
        chk("1.5x2.0 Multip",    64'(mult_s), 64'h0000_0000_0300_0000);
        chk("1.5x2.0 Resultado", 64'(res_s),  64'h0000_0000_0000_3000);

        do_op(24'h800000, 24'h800000, 1'b0);
        chk("min x min Multip",    64'(mult_s), 64'h0000_4000_0000_0000);
        chk("min x min Resultado", 64'(res_s),  64'h0000_0000_007F_FFFF);
        chk("min x min Overflow",  64'(ovf_s),  64'd1);

        do_op(24'h000123, 24'h000456, 1'b1);

        for (int i = 0; i < 8; i++) do_op(tab_a[i], tab_b[i], 1'b0);
        for (int i = 0; i < 25; i++) do_op(N'($urandom), N'($urandom), (i % 7) == 3);

        // Reset 10 cycles into CALC must abort with no Listo.
        @(negedge clk);
        op_a = 24'h00ABCD; op_b = 24'h001234; inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort Ocupado",   64'(ocup_s), 64'd0);
        chk("abort Listo",     64'(listo_u), 64'd0);
        chk("abort Multip",    64'(mult_s), 64'd0);
        chk("abort Resultado", 64'(res_u),  64'd0);
        chk("abort Overflow",  64'(ovf_s),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (N + 5) @(negedge clk);

        do_op(24'd7, 24'd6, 1'b0);
        chk("7x6 unsigned Multip", 64'(mult_u), 64'd42);
        chk("7x6 signed Multip",   64'(mult_s), 64'd42);

        repeat (4) @(negedge clk);
        chk("pending expectations", 64'(q_s.size() + q_u.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
